// File: rtl/fetch_seq.sv
// -----------------------------------------------------------------------------
// fetch_seq -- fetch-stage sequencer
//
// Sits between the instruction memory, the PC register and the F/D pipeline
// register. It runs the imem req/ack handshake, advances the PC, writes the
// fetched word into F/D, and parks that word in a holding buffer while decode
// stalls. It applies branch/jump redirects with an F/D flush. A request that
// waits too long for its ack raises a sticky error and freezes the
// sequencer until reset.
//
// Ports
//   clk            in   1   clock, all state updates on the rising edge
//   reset_n        in   1   synchronous active-low reset
//   pc_i           in   32  current PC register value
//   pc_wren_o      out  1   PC register write enable
//   pc_jmp_to_o    out  32  value written into the PC register
//   imem_req_o     out  1   instruction fetch request
//   imem_addr_o    out  32  instruction fetch address
//   imem_ack_i     in   1   fetch complete, imem_rdata_i valid this cycle
//   imem_rdata_i   in   32  fetched instruction word
//   stall_i        in   1   decode cannot accept new F/D contents
//   redirect_i     in   1   taken branch/jump pulse from execute
//   redirect_pc_i  in   32  redirect target
//   fd_wren_o      out  1   F/D register write enable
//   fd_ins_o       out  32  instruction written into F/D
//   fd_next_pc_o   out  32  next_pc written into F/D
//   fetch_err_o    out  1   sticky fetch timeout flag
// -----------------------------------------------------------------------------
module fetch_seq #(
  parameter logic [31:0] NOP_INSN = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_i,
  output logic        pc_wren_o,
  output logic [31:0] pc_jmp_to_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        fd_wren_o,
  output logic [31:0] fd_ins_o,
  output logic [31:0] fd_next_pc_o,
  output logic        fetch_err_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    ERR   = 3'd4
  } state_t;

  // Sequential PC increment; the 32-bit sum wraps naturally at 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

  // Saturating increment for the 8-bit wait counter.
  function automatic logic [7:0] tmo_sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : (cnt + 8'd1);
  endfunction

  state_t      state_q, state_d;
  logic [31:0] hold_ins_q, hold_ins_d;
  logic [31:0] hold_npc_q, hold_npc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        fetch_err_q, fetch_err_d;

  logic        pc_wren_s;
  logic [31:0] pc_jmp_to_s;
  logic        imem_req_s;
  logic [31:0] imem_addr_s;
  logic        fd_wren_s;
  logic [31:0] fd_ins_s;
  logic [31:0] fd_next_pc_s;
  logic [31:0] npc_s;
  logic        tmo_expired_s;

  assign npc_s         = pc_inc(pc_i);
  assign tmo_expired_s = (TIMEOUT != 8'd0) && (tmo_cnt_q == TIMEOUT);

  // Next-state and output decode for the fetch FSM.
  always_comb begin
    state_d      = state_q;
    hold_ins_d   = hold_ins_q;
    hold_npc_d   = hold_npc_q;
    drain_addr_d = drain_addr_q;
    tmo_cnt_d    = tmo_cnt_q;
    fetch_err_d  = fetch_err_q;
    pc_wren_s    = 1'b0;
    pc_jmp_to_s  = 32'h0000_0000;
    imem_req_s   = 1'b0;
    imem_addr_s  = 32'h0000_0000;
    fd_wren_s    = 1'b0;
    fd_ins_s     = 32'h0000_0000;
    fd_next_pc_s = 32'h0000_0000;

    // A redirect always wins over stall and ack, except once in ERR.
    if (redirect_i && (state_q != ERR)) begin
      pc_wren_s    = 1'b1;
      pc_jmp_to_s  = redirect_pc_i;
      fd_wren_s    = 1'b1;
      fd_ins_s     = NOP_INSN;
      fd_next_pc_s = 32'h0000_0000;
    end else begin
      fd_wren_s    = 1'b0;
    end

    case (state_q)
      IDLE: begin
        tmo_cnt_d = 8'd0;
        state_d   = REQ;
      end

      REQ: begin
        imem_req_s  = 1'b1;
        imem_addr_s = pc_i;
        if (redirect_i) begin
          tmo_cnt_d = 8'd0;
          if (imem_ack_i) begin
            state_d = REQ;
          end else if (tmo_expired_s) begin
            state_d     = ERR;
            fetch_err_d = 1'b1;
          end else begin
            // The outstanding request must still complete at its own address.
            drain_addr_d = pc_i;
            state_d      = DRAIN;
          end
        end else if (imem_ack_i) begin
          tmo_cnt_d   = 8'd0;
          pc_wren_s   = 1'b1;
          pc_jmp_to_s = npc_s;
          if (stall_i) begin
            hold_ins_d = imem_rdata_i;
            hold_npc_d = npc_s;
            state_d    = HOLD;
          end else begin
            fd_wren_s    = 1'b1;
            fd_ins_s     = imem_rdata_i;
            fd_next_pc_s = npc_s;
            state_d      = REQ;
          end
        end else if (tmo_expired_s) begin
          state_d     = ERR;
          fetch_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_sat_inc(tmo_cnt_q);
        end
      end

      HOLD: begin
        // No request is outstanding here, so any ack is ignored.
        tmo_cnt_d = 8'd0;
        if (redirect_i) begin
          state_d = REQ;
        end else if (!stall_i) begin
          fd_wren_s    = 1'b1;
          fd_ins_s     = hold_ins_q;
          fd_next_pc_s = hold_npc_q;
          state_d      = REQ;
        end else begin
          state_d = HOLD;
        end
      end

      DRAIN: begin
        // Finish the abandoned request; its data is discarded.
        imem_req_s  = 1'b1;
        imem_addr_s = drain_addr_q;
        if (imem_ack_i) begin
          tmo_cnt_d = 8'd0;
          state_d   = REQ;
        end else if (tmo_expired_s) begin
          state_d     = ERR;
          fetch_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_sat_inc(tmo_cnt_q);
        end
      end

      ERR: begin
        fetch_err_d = 1'b1;
        state_d     = ERR;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hold_ins_q   <= 32'h0000_0000;
      hold_npc_q   <= 32'h0000_0000;
      drain_addr_q <= 32'h0000_0000;
      tmo_cnt_q    <= 8'd0;
      fetch_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_ins_q   <= hold_ins_d;
      hold_npc_q   <= hold_npc_d;
      drain_addr_q <= drain_addr_d;
      tmo_cnt_q    <= tmo_cnt_d;
      fetch_err_q  <= fetch_err_d;
    end
  end

  // Enables and request are forced low for as long as reset is asserted.
  assign pc_wren_o    = reset_n & pc_wren_s;
  assign imem_req_o   = reset_n & imem_req_s;
  assign fd_wren_o    = reset_n & fd_wren_s;
  assign pc_jmp_to_o  = pc_jmp_to_s;
  assign imem_addr_o  = imem_addr_s;
  assign fd_ins_o     = fd_ins_s;
  assign fd_next_pc_o = fd_next_pc_s;
  assign fetch_err_o  = fetch_err_q;

endmodule
